// File: rtl/mul_controller.sv
// mul_controller: control FSM for the repeated-addition multiplier.
//   Inputs : clk, rst (sync, active-high), start, in_valid, eqz (datapath B==0)
//   Outputs: in_ready, lda, ldb, clrp, ldp, decb, busy, done, err
//   Optional MUL_CTRL_TIMEOUT_EN adds a CNT_W-bit add-iteration counter that
//   aborts ADD with err after MAX_ITER iterations; otherwise err is tied 0.
module mul_controller
`ifdef MUL_CTRL_TIMEOUT_EN
  #(
    parameter int unsigned CNT_W = 16,
    parameter logic [CNT_W-1:0] MAX_ITER = {CNT_W{1'b1}}
  )
`endif
  (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_valid,
  input  logic eqz,
  output logic in_ready,
  output logic lda,
  output logic ldb,
  output logic clrp,
  output logic ldp,
  output logic decb,
  output logic busy,
  output logic done,
  output logic err
);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, ADD, DONE} state_t;
  state_t state_q, state_d;
  logic abort;
`ifdef MUL_CTRL_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic accept;
  assign accept = state_q == IDLE && start;
  assign abort = state_q == ADD && !eqz && cnt_q == MAX_ITER;
  always_comb begin
    cnt_d = accept ? '0 : ldp ? cnt_q + 1'b1 : cnt_q;
    err_d = accept ? 1'b0 : abort ? 1'b1 : err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign abort = 1'b0;
  assign err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? LOAD_A : IDLE;
      LOAD_A:  state_d = in_valid ? LOAD_B : LOAD_A;
      LOAD_B:  state_d = in_valid ? ADD : LOAD_B;
      ADD:     state_d = (eqz || abort) ? DONE : ADD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state_q == LOAD_A || state_q == LOAD_B;
    lda = state_q == LOAD_A && in_valid;
    ldb = state_q == LOAD_B && in_valid;
    clrp = ldb;
    ldp = state_q == ADD && !eqz && !abort;
    decb = ldp;
    busy = state_q != IDLE;
    done = state_q == DONE;
  end
endmodule

// File: tb/tb_mul_controller.sv
// tb_mul_controller: directed bench for mul_controller with a behavioural datapath.
module tb_mul_controller;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, eqz;
  logic in_ready, lda, ldb, clrp, ldp, decb, busy, done, err;
  logic [15:0] data_in = '0, a_r = '0, b_r = '0;
  logic [31:0] p_r = '0;
  logic [8:0] outs;
  int checks = 0, failures = 0;
  int nldp = 0, ndecb = 0, nbad = 0;
  always #5 clk = ~clk;
`ifdef MUL_CTRL_TIMEOUT_EN
  localparam int MAXI = 3;
  mul_controller #(.CNT_W(16), .MAX_ITER(16'd3)) dut (
`else
  localparam int MAXI = 1 << 20;
  mul_controller dut (
`endif
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .eqz(eqz),
    .in_ready(in_ready), .lda(lda), .ldb(ldb), .clrp(clrp), .ldp(ldp),
    .decb(decb), .busy(busy), .done(done), .err(err)
  );
  assign outs = {in_ready, lda, ldb, clrp, ldp, decb, busy, done, err};
  assign eqz = b_r == 16'd0;
  always @(posedge clk) begin
    if (lda) a_r <= data_in;
    if (ldb) b_r <= data_in;
    if (clrp) p_r <= '0;
    if (ldp) p_r <= p_r + {16'd0, a_r};
    if (decb) b_r <= b_r - 16'd1;
  end
  always @(posedge clk) begin
    if (!rst) begin
      nldp <= nldp + int'(ldp);
      ndecb <= ndecb + int'(decb);
      nbad <= nbad + int'(((lda || ldb) && !in_valid) || (ldb != clrp) || (ldp != decb)
                          || (int'(lda) + int'(ldb) + int'(ldp) > 1)
                          || ((lda || ldb) && !in_ready) || (done && (lda || ldb || ldp)));
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic run(input logic [15:0] a, input logic [15:0] b, input int ga, input int gb, input bit noise);
    int l0 = nldp, d0 = ndecb, b0 = nbad;
    int lat = 0, rdy_low = 0, busy_low = 0;
    int eff = (int'(b) > MAXI) ? MAXI : int'(b);
    logic err_done = 1'b0, err_first = 1'b1;
    bit held = ga == 0 && gb == 0;
    @(negedge clk);
    start = 1'b1;
    in_valid = held;
    data_in = a;
    for (int n = 1; n <= 400 && lat == 0; n++) begin
      @(negedge clk);
      start = noise && n >= ga + gb + 3;
      in_valid = held || n == ga + 1 || n == ga + gb + 2;
      data_in = n <= ga + 1 ? a : n <= ga + gb + 2 ? b : 16'hDEAD;
      #1;
      if (n <= ga + gb + 2 && !in_ready) rdy_low++;
      if (!busy) busy_low++;
      if (n == 1) err_first = err;
      if (done) begin
        lat = n;
        err_done = err;
      end
    end
    check("latency", lat, eff + ga + gb + 4);
    check("product", p_r, {16'd0, a} * 32'(eff));
    check("ldp_count", nldp - l0, eff);
    check("decb_count", ndecb - d0, eff);
    check("strobe_rules", nbad - b0, 0);
    check("in_ready_held", rdy_low, 0);
    check("busy_held", busy_low, 0);
    check("err_at_done", {31'd0, err_done}, {31'd0, int'(b) > MAXI});
    check("err_cleared", {31'd0, err_first}, 0);
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    #1;
    check("idle_after", {31'd0, busy}, 0);
  endtask
  initial begin
    int k = MAXI >= 50 ? 50 : 2;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outs", {23'd0, outs}, 0);
    rst = 1'b0;
    run(16'd17, 16'd5, 0, 0, 0);
    run(16'd1234, 16'd0, 0, 0, 0);
    run(16'd9, 16'd6, 3, 2, 0);
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b1;
    data_in = 16'd3;
    for (int n = 1; n <= k + 2; n++) begin
      @(negedge clk);
      start = 1'b0;
      data_in = n == 1 ? 16'd3 : 16'd200;
    end
    #1;
    check("mid_add_ldp", {31'd0, ldp}, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("mid_reset_outs", {23'd0, outs}, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    run(16'd2, 16'd7, 0, 0, 0);
    run(16'd5, 16'd3, 0, 0, 1);
    run(16'd4, 16'd5, 0, 0, 0);
    run(16'd6, 16'd2, 0, 0, 0);
    run(16'd11, 16'd1, 1, 1, 1);
    run(16'hFFFF, 16'd3, 0, 2, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
